// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Shares the single register-file write port between CPU writeback (fixed
// priority) and four one-deep bike orientation buffers granted round-robin
// in idle write slots. All outputs are registered.
// Optional feature macro: STARVE_GUARD_EN (per-bike age counters that force
// a bike grant and raise cpu_stall once a bike has waited STARVE_LIMIT cycles).
module regfile_write_arbiter #(
    parameter int                DATA_W       = 32,
    parameter int                REG_W        = 5,
    parameter logic [REG_W-1:0]  ORIENT_REG0  = REG_W'(2),
    parameter logic [REG_W-1:0]  ORIENT_REG1  = REG_W'(4),
    parameter logic [REG_W-1:0]  ORIENT_REG2  = REG_W'(6),
    parameter logic [REG_W-1:0]  ORIENT_REG3  = REG_W'(8),
    parameter int                STARVE_LIMIT = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                cpu_wen,
    input  logic [REG_W-1:0]    cpu_rd,
    input  logic [DATA_W-1:0]   cpu_data,
    input  logic [3:0]          bike_req,
    input  logic [4*DATA_W-1:0] bike_data,
    input  logic                master_switch,
    output logic [3:0]          bike_ack,
    output logic                wr_en,
    output logic [REG_W-1:0]    wr_reg,
    output logic [DATA_W-1:0]   wr_data,
    output logic                busy,
    output logic                cpu_stall
);

    // The age counters are 8 bits wide, so the limit must fit in 1..255.
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_starve_limit
        $error("STARVE_LIMIT must be in 1..255");
    end

    logic [3:0]        pending_q, pending_d;
    logic [DATA_W-1:0] buf_q [4];
    logic [DATA_W-1:0] buf_d [4];
    logic [1:0]        rr_ptr_q, rr_ptr_d;
    logic [3:0]        bike_ack_q, bike_ack_d;
    logic              wr_en_q, wr_en_d;
    logic [REG_W-1:0]  wr_reg_q, wr_reg_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              busy_q, busy_d;

    logic              cpu_win;
    logic              grant_valid;
    logic [1:0]        grant_idx;
    logic              rr_found;
    logic [1:0]        rr_idx;

    function automatic logic [REG_W-1:0] orient_reg(input logic [1:0] idx);
        case (idx)
            2'd0:    return ORIENT_REG0;
            2'd1:    return ORIENT_REG1;
            2'd2:    return ORIENT_REG2;
            default: return ORIENT_REG3;
        endcase
    endfunction

    // Round-robin search: first pending bike starting at rr_ptr.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = 2'd0;
        for (int k = 0; k < 4; k++) begin
            if (!rr_found && pending_q[rr_ptr_q + 2'(k)]) begin
                rr_found = 1'b1;
                rr_idx   = rr_ptr_q + 2'(k);
            end
        end
    end

`ifdef STARVE_GUARD_EN
    localparam logic [7:0] STARVE_LIMIT_C = 8'(STARVE_LIMIT);

    logic [7:0] age_q [4];
    logic [7:0] age_d [4];
    logic       cpu_stall_q, cpu_stall_d;
    logic       starve_any;
    logic [1:0] starve_idx;
    logic [7:0] starve_age;

    // Pick the oldest bike at or past the limit; ascending scan keeps ties at the lowest index.
    always_comb begin
        starve_any = 1'b0;
        starve_idx = 2'd0;
        starve_age = 8'd0;
        for (int i = 0; i < 4; i++) begin
            if (master_switch && pending_q[i] && (age_q[i] >= STARVE_LIMIT_C) &&
                (!starve_any || (age_q[i] > starve_age))) begin
                starve_any = 1'b1;
                starve_idx = 2'(i);
                starve_age = age_q[i];
            end
        end
    end

    // Slot decision: a starving bike pre-empts the CPU, otherwise CPU first, then round-robin.
    always_comb begin
        cpu_stall_d = 1'b0;
        if (starve_any) begin
            cpu_win     = 1'b0;
            grant_valid = 1'b1;
            grant_idx   = starve_idx;
            cpu_stall_d = 1'b1;
        end else begin
            cpu_win     = cpu_wen && (cpu_rd != '0);
            grant_valid = !cpu_win && master_switch && rr_found;
            grant_idx   = rr_idx;
        end
    end

    // Age counts waiting cycles of a pending bike while the game runs; it clears when served or idle.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            age_d[i] = age_q[i];
            if (!pending_q[i] || (grant_valid && (grant_idx == 2'(i)))) begin
                age_d[i] = 8'd0;
            end else if (master_switch && (age_q[i] != 8'hFF)) begin
                age_d[i] = age_q[i] + 8'd1;
            end
        end
    end

    // Age and stall registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) age_q[i] <= 8'd0;
            cpu_stall_q <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) age_q[i] <= age_d[i];
            cpu_stall_q <= cpu_stall_d;
        end
    end

    assign cpu_stall = cpu_stall_q;
`else
    // Slot decision: CPU writeback to a nonzero register wins, otherwise round-robin.
    always_comb begin
        cpu_win     = cpu_wen && (cpu_rd != '0);
        grant_valid = !cpu_win && master_switch && rr_found;
        grant_idx   = rr_idx;
    end

    assign cpu_stall = 1'b0;
`endif

    // Next state: drive the write port from the winner, then capture new bike data.
    always_comb begin
        pending_d  = pending_q;
        buf_d      = buf_q;
        rr_ptr_d   = rr_ptr_q;
        bike_ack_d = bike_req;
        wr_en_d    = 1'b0;
        wr_reg_d   = wr_reg_q;
        wr_data_d  = wr_data_q;

        if (cpu_win) begin
            wr_en_d   = 1'b1;
            wr_reg_d  = cpu_rd;
            wr_data_d = cpu_data;
        end else if (grant_valid) begin
            wr_en_d              = 1'b1;
            wr_reg_d             = orient_reg(grant_idx);
            wr_data_d            = buf_q[grant_idx];
            pending_d[grant_idx] = 1'b0;
            rr_ptr_d             = grant_idx + 2'd1;
        end

        // Capture after the grant so a same-cycle request re-arms the buffer with the newest value.
        for (int i = 0; i < 4; i++) begin
            if (bike_req[i]) begin
                buf_d[i]     = bike_data[i*DATA_W +: DATA_W];
                pending_d[i] = 1'b1;
            end
        end

        busy_d = |pending_d;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            pending_q  <= 4'd0;
            for (int i = 0; i < 4; i++) buf_q[i] <= '0;
            rr_ptr_q   <= 2'd0;
            bike_ack_q <= 4'd0;
            wr_en_q    <= 1'b0;
            wr_reg_q   <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            for (int i = 0; i < 4; i++) buf_q[i] <= buf_d[i];
            rr_ptr_q   <= rr_ptr_d;
            bike_ack_q <= bike_ack_d;
            wr_en_q    <= wr_en_d;
            wr_reg_q   <= wr_reg_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
        end
    end

    assign bike_ack = bike_ack_q;
    assign wr_en    = wr_en_q;
    assign wr_reg   = wr_reg_q;
    assign wr_data  = wr_data_q;
    assign busy     = busy_q;

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Shares the single register-file write port (enable, register index, data) between processor writeback and four bike orientation input sources (one per player controller).
- CPU writeback has fixed priority.
- Bike updates are buffered one-deep per bike and granted round-robin in idle write slots.
- Sits between writeback/controller decoders and the decode-stage register file; output drives its write-enable/rd/data inputs.

Parameters:
DATA_W, 32, write data width
REG_W, 5, register index width
ORIENT_REG0, 5'd2, register index written for bike one orientation
ORIENT_REG1, 5'd4, register index for bike two orientation
ORIENT_REG2, 5'd6, register index for bike three orientation
ORIENT_REG3, 5'd8, register index for bike four orientation
STARVE_LIMIT, 16, pending-cycle limit used by the optional feature (1..255)

Ports:
clock  in  1  single system clock, rising edge
reset  in  1  synchronous, active-high
cpu_wen  in  1  writeback write enable
cpu_rd  in  REG_W  writeback destination register
cpu_data  in  DATA_W  writeback data
bike_req  in  4  per-bike update request, bit i = bike i
bike_data  in  4*DATA_W  bike i data at bits [i*DATA_W +: DATA_W]
master_switch  in  1  game running; 0 freezes bike grants
bike_ack  out  4  one-cycle capture acknowledge per bike
wr_en  out  1  register-file write enable
wr_reg  out  REG_W  register-file write index
wr_data  out  DATA_W  register-file write data
busy  out  1  any bike update pending
cpu_stall  out  1  writeback hold request; tied 0 unless the optional feature is compiled in

Behaviour:
- Reset (synchronous, active-high): wr_en=0, wr_reg=0, wr_data=0, bike_ack=0, busy=0, cpu_stall=0. All pending flags and buffers are cleared. rr_ptr=0. Reset mid-operation discards pending updates.
- Capture:
  - bike_req[i]=1 at an edge loads buffer i with bike_data slice i and sets pending[i].
  - bike_ack[i]=1 for exactly the next cycle.
  - req held high captures every cycle, with an ack every cycle.
  - If buffer i is already pending, new data overwrites it (latest orientation wins).
- CPU slot: cpu_wen=1 with cpu_rd!=0 wins the cycle. cpu_wen with cpu_rd=0 is a free slot; register 0 is never written.
- Bike slot: in a free slot with master_switch=1 and pending!=0:
  - Grant the first pending bike searching rr_ptr, rr_ptr+1, ... (mod 4).
  - Write ORIENT_REGi with buffer i.
  - Set rr_ptr = granted+1 (wraps 3->0).
- master_switch=0: no bike grants; pending data is held, and capture still occurs.
- Simultaneous grant and new req on the same bike: new data is captured and pending stays set. The granted write uses the old buffer value.
- Latency: outputs are registered. The decision made at edge N appears on wr_* during cycle N+1. In cycles with no grant, wr_en=0 and wr_reg/wr_data hold their previous values.
- CPU writes to an ORIENT_REGi while bike i is pending: no interaction; the later bike write overwrites.
- busy = |pending, registered.

Optional Feature:
STARVE_GUARD_EN
- Defined:
  - Each bike has an 8-bit age counter that increments each cycle while it is pending, master_switch=1, and it is not granted. The counter clears on grant or reset.
  - When any age reaches STARVE_LIMIT, cpu_stall is registered high for one cycle.
  - In that cycle cpu_wen is ignored, and the oldest starving bike is granted; ties go to the lowest index.
  - rr_ptr updates as for a normal grant.
  - The writeback stage must hold its write while cpu_stall=1.
- Undefined: no counters; cpu_stall constant 0; CPU always wins.

Test Plan:
1. Reset held 2 cycles, then bike_req=4'b0001 with data 0x00000003 and cpu_wen=0 -> bike_ack[0]=1 one cycle after the edge; write of reg 2 = 0x3 one cycle after capture; busy returns to 0.
2. All four bikes request in the same cycle, data 0x10..0x13, no CPU writes -> writes to reg 2, 4, 6, 8 in consecutive cycles; a second burst starts at bike 0 again (rr_ptr wrapped).
3. cpu_wen=1, cpu_rd=9, data 0xAAAA continuously, bike 1 pending -> only reg 9 is written. After cpu_wen drops, reg 4 is written next cycle. With STARVE_GUARD_EN and STARVE_LIMIT=16, cpu_stall pulses once and reg 4 is written after 16 pending cycles.
4. cpu_wen=1 with cpu_rd=0 while bike 2 is pending -> reg 6 is written that slot and register 0 is never written.
5. master_switch=0, bike 3 requests 0x1 then 0x2 -> two acks, no writes. Raising master_switch gives exactly one write of reg 8 = 0x2.
6. Reset asserted while bikes 0 and 1 are pending -> no writes after reset, busy=0, outputs all zero.
